n64_flashram_engine: RTL



---
 rtl/n64_flashram_engine.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/n64_flashram_engine.sv
// n64_flashram_engine: FlashRAM backend executor.
// Holds the 64 x 16 page buffer and performs page program, sector erase and
// chip erase against the SDRAM save region through a request/ack word port.
// Optional build macro FLASHRAM_PROGRAM_AND_EN: program becomes a
// read-modify-write that ANDs the buffer word into the stored word.
module n64_flashram_engine #(
  parameter logic [26:0] BASE_ADDRESS = 27'h3FE_0000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        pending,
  input  logic        write_or_erase,
  input  logic        sector_or_all,
  input  logic [9:0]  page,
  output logic        done,
  input  logic        buf_write,
  input  logic [5:0]  buf_address,
  input  logic [15:0] buf_wdata,
  output logic        mem_request,
  output logic        mem_write,
  output logic [26:0] mem_address,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ack
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t      state_q, state_d;
  logic [15:0] counter_q, counter_d;
  logic [9:0]  page_q, page_d;
  logic        erase_q, erase_d;
  logic        all_q, all_d;
  logic        done_q, done_d;
  logic        mem_request_q, mem_request_d;
  logic        mem_write_q, mem_write_d;
  logic [26:0] mem_address_q, mem_address_d;
  logic [15:0] mem_wdata_q, mem_wdata_d;

  logic [15:0] page_buf [64];
  logic        buf_lock;
  logic [15:0] last_word;
  logic [15:0] next_count;

`ifndef FLASHRAM_PROGRAM_AND_EN
  // Read data is only consumed by the read-modify-write build.
  logic unused_rdata;
  assign unused_rdata = ^mem_rdata;
`endif

  // Byte address of word cnt of the selected operation inside the save region.
  function automatic logic [26:0] word_address(input logic erase, input logic all,
                                               input logic [9:0] pg, input logic [15:0] cnt);
    logic [16:0] offset;
    if (!erase)   offset = {pg, 7'b0};
    else if (all) offset = 17'd0;
    else          offset = {pg[9:7], 14'b0};
    return BASE_ADDRESS + {10'b0, offset} + {10'b0, cnt, 1'b0};
  endfunction

  // The buffer feeds an in-flight program, so it is frozen only then; erases leave it writable.
  assign buf_lock = (state_q != IDLE) && !erase_q;

  // Page buffer write port; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (buf_write && !buf_lock) page_buf[buf_address] <= buf_wdata;
  end

  // Index of the final word for the latched operation.
  always_comb begin
    last_word = 16'd63;
    if (erase_q) last_word = all_q ? 16'hFFFF : 16'h1FFF;
  end

  assign next_count = counter_q + 16'd1;

  // Next-state and next-output logic; outputs only move on a start, an ack or completion.
  always_comb begin
    state_d       = state_q;
    counter_d     = counter_q;
    page_d        = page_q;
    erase_d       = erase_q;
    all_d         = all_q;
    done_d        = 1'b0;
    mem_request_d = mem_request_q;
    mem_write_d   = mem_write_q;
    mem_address_d = mem_address_q;
    mem_wdata_d   = mem_wdata_q;
    case (state_q)
      IDLE: begin
        if (pending) begin
          page_d        = page;
          erase_d       = write_or_erase;
          all_d         = sector_or_all;
          counter_d     = 16'd0;
          mem_request_d = 1'b1;
          mem_address_d = word_address(write_or_erase, sector_or_all, page, 16'd0);
`ifdef FLASHRAM_PROGRAM_AND_EN
          if (!write_or_erase) begin
            state_d     = READ;
            mem_write_d = 1'b0;
          end else begin
            state_d     = WRITE;
            mem_write_d = 1'b1;
            mem_wdata_d = 16'hFFFF;
          end
`else
          state_d     = WRITE;
          mem_write_d = 1'b1;
          mem_wdata_d = write_or_erase ? 16'hFFFF : page_buf[6'd0];
`endif
        end
      end
`ifdef FLASHRAM_PROGRAM_AND_EN
      READ: begin
        if (mem_ack) begin
          state_d     = WRITE;
          mem_write_d = 1'b1;
          mem_wdata_d = mem_rdata & page_buf[counter_q[5:0]];
        end
      end
`endif
      WRITE: begin
        if (mem_ack) begin
          if (counter_q == last_word) begin
            state_d       = DONE;
            mem_request_d = 1'b0;
            done_d        = 1'b1;
          end else begin
            counter_d     = next_count;
            mem_address_d = word_address(erase_q, all_q, page_q, next_count);
`ifdef FLASHRAM_PROGRAM_AND_EN
            if (!erase_q) begin
              state_d     = READ;
              mem_write_d = 1'b0;
            end else begin
              mem_wdata_d = 16'hFFFF;
            end
`else
            mem_wdata_d = erase_q ? 16'hFFFF : page_buf[next_count[5:0]];
`endif
          end
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs; reset abandons any operation without a done pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      counter_q     <= 16'd0;
      page_q        <= 10'd0;
      erase_q       <= 1'b0;
      all_q         <= 1'b0;
      done_q        <= 1'b0;
      mem_request_q <= 1'b0;
      mem_write_q   <= 1'b0;
      mem_address_q <= BASE_ADDRESS;
      mem_wdata_q   <= 16'd0;
    end else begin
      state_q       <= state_d;
      counter_q     <= counter_d;
      page_q        <= page_d;
      erase_q       <= erase_d;
      all_q         <= all_d;
      done_q        <= done_d;
      mem_request_q <= mem_request_d;
      mem_write_q   <= mem_write_d;
      mem_address_q <= mem_address_d;
      mem_wdata_q   <= mem_wdata_d;
    end
  end

  assign done        = done_q;
  assign mem_request = mem_request_q;
  assign mem_write   = mem_write_q;
  assign mem_address = mem_address_q;
  assign mem_wdata   = mem_wdata_q;

endmodule
